osd_stm_mux: RTL
================

OSD_STM_MUX -- requirements
Module: osd_stm_mux

Interface
REQ-001 SHALL have parameter XLEN, default 64, trace value width.
REQ-002 SHALL have parameter NUM_CH, default 4, trace channel count (1..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event buffer depth (power of 2, >=2).
REQ-004 SHALL have parameter TS_WIDTH, default 32, timestamp width.
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-007 SHALL have port trace_valid  in  NUM_CH  per-channel sample strobe, no backpressure.
REQ-008 SHALL have port trace_id  in  NUM_CH*16  per-channel 16-bit id, channel i at [16i+:16].
REQ-009 SHALL have port trace_value  in  NUM_CH*XLEN  per-channel value, channel i at [XLEN*i+:XLEN].
REQ-010 SHALL have port ch_enable  in  NUM_CH  per-channel enable from register file.
REQ-011 SHALL have port stall  in  1  global trace stall.
REQ-012 SHALL have port out_valid  out  1  event available.
REQ-013 SHALL have port out_ready  in  1  consumer accepts event.
REQ-014 SHALL have port out_data  out  EW  event {ch, drops[7:0], value, id, timestamp}; CH_W=max(1,clog2(NUM_CH)), EW=CH_W+8+XLEN+16+TS_WIDTH.

Function
REQ-015 SHALL run a free-running TS_WIDTH timestamp counter, +1 per cycle, wrapping to 0.
REQ-016 SHALL hold one capture slot per channel; sample on channel i accepted when trace_valid[i] & ch_enable[i] & !stall.
REQ-017 SHALL store accepted sample as {id, value, current timestamp}; slot becomes full next cycle.
REQ-018 SHALL, when slot i full and not granted, drop an accepted sample and increment 8-bit drop counter i, saturating at 255.
REQ-019 SHALL not count samples ignored by stall or ch_enable as drops.
REQ-020 SHALL, when slot i granted in same cycle as accepted sample, refill slot i with new sample (no drop).
REQ-021 SHALL grant at most one full slot per cycle, only when FIFO not full, round-robin starting at channel (last_grant+1) mod NUM_CH.
REQ-022 SHALL write granted event with drops = drop counter i value and clear counter i same cycle.
REQ-023 SHALL drain already-full slots after ch_enable[i] or stall deasserts acceptance.
REQ-024 SHALL buffer events in a FIFO_DEPTH show-ahead FIFO; out_data valid when out_valid=1, pop on out_valid & out_ready.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL treat FIFO full as blocking grants even if pop occurs same cycle (no full-bypass).
REQ-027 SHALL have minimum latency 2 cycles: sample at cycle n, out_valid at n+2 with empty FIFO.
REQ-028 SHALL preserve per-channel event order.

Reset
REQ-029 SHALL on rst=0 clear timestamp, all slots, drop counters, FIFO pointers; last_grant = NUM_CH-1.
REQ-030 SHALL drive out_valid=0 and out_data=0 during and after reset until first event.
REQ-031 SHALL discard in-flight samples and events on reset mid-operation; no partial event emitted.

Structure
REQ-032 SHALL place CH_W function, drop counter width (8), event field offsets in shared package osd_stm_package.
REQ-033 SHALL implement arbitration in sub-module osd_rr_arbiter (NUM_CH request/grant, one-hot grant, advance on grant).
REQ-034 SHALL keep FIFO inline using the same async active-low reset (no reuse of sync-reset buffers).

Verification (NUM_CH=4, XLEN=32, FIFO_DEPTH=4, TS_WIDTH=32)
REQ-035 SHALL cover: reset release, ch0 sample id=0x0011 value=0xDEADBEEF at ts=5 -> out_valid at ts=7, out_data {ch=0, drops=0, 0xDEADBEEF, 0x0011, 5}.
REQ-036 SHALL cover: all 4 channels strobe same cycle, out_ready=1 -> events in order ch0, ch1, ch2, ch3, consecutive cycles, drops=0.
REQ-037 SHALL cover: out_ready=0, ch2 strobes every cycle for 300 cycles -> 4 FIFO events + 1 slot; release -> next ch2 event after slot shows drops=255 (saturated), following drops=0.
REQ-038 SHALL cover: stall=1 or ch_enable[1]=0 while ch1 strobes 10 cycles -> no events, ch1 drop counter remains 0.
REQ-039 SHALL cover: timestamp 0xFFFFFFFF sample then next cycle sample -> timestamps 0xFFFFFFFF then 0x00000000.
REQ-040 SHALL cover: rst=0 asserted with 3 events buffered and out_ready=0 -> out_valid=0 immediately (async), no stale event after release.

Source files
------------

// File: rtl/osd_stm_mux_pkg.sv
// Shared sizing helpers and event field layout for the trace multiplexer.
// Event word, LSB first: timestamp, id, value, drops, channel.
package osd_stm_package;

  localparam int DROP_W = 8;
  localparam int ID_W   = 16;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int id_lsb(input int ts_width);
    return ts_width;
  endfunction

  function automatic int value_lsb(input int ts_width);
    return ts_width + ID_W;
  endfunction

  function automatic int drops_lsb(input int ts_width, input int xlen);
    return ts_width + ID_W + xlen;
  endfunction

  function automatic int ch_lsb(input int ts_width, input int xlen);
    return ts_width + ID_W + xlen + DROP_W;
  endfunction

  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] d);
    return (d == {DROP_W{1'b1}}) ? d : d + DROP_W'(1);
  endfunction

endpackage

// File: rtl/osd_stm_mux_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starts after
// the most recent winner and only advances when a grant is issued.
module osd_rr_arbiter
  import osd_stm_package::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_valid
);

  logic [CH_W-1:0] last_r;
  int              sel_s;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    sel_s = -1;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int idx;
      idx   = (int'(last_r) + 1 + k) % NUM_CH;
      sel_s = req[idx] ? idx : sel_s;
    end
    gnt_valid    = en && (sel_s >= 0);
    gnt_idx      = gnt_valid ? CH_W'(sel_s) : '0;
    gnt          = '0;
    gnt[gnt_idx] = gnt_valid;
  end

  // Remember the last winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= CH_W'(NUM_CH - 1);
    end else if (gnt_valid) begin
      last_r <= gnt_idx;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/osd_stm_mux.sv
// Trace multiplexer: per-channel capture slots with saturating drop counts,
// round-robin drain into a show-ahead event FIFO.
module osd_stm_mux
  import osd_stm_package::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 32,
  localparam int CH_W      = ch_w(NUM_CH),
  localparam int EW        = CH_W + DROP_W + XLEN + ID_W + TS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      trace_valid,
  input  logic [NUM_CH*16-1:0]   trace_id,
  input  logic [NUM_CH*XLEN-1:0] trace_value,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic                   stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EW-1:0]          out_data
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int ID_LSB    = id_lsb(TS_WIDTH);
  localparam int VALUE_LSB = value_lsb(TS_WIDTH);
  localparam int DROPS_LSB = drops_lsb(TS_WIDTH, XLEN);
  localparam int CH_LSB    = ch_lsb(TS_WIDTH, XLEN);

  logic [TS_WIDTH-1:0] ts_r;
  logic [NUM_CH-1:0]   slot_full_r;
  logic [ID_W-1:0]     slot_id_r    [NUM_CH];
  logic [XLEN-1:0]     slot_val_r   [NUM_CH];
  logic [TS_WIDTH-1:0] slot_ts_r    [NUM_CH];
  logic [DROP_W-1:0]   drop_r       [NUM_CH];

  logic [EW-1:0]       mem_r        [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;

  logic [NUM_CH-1:0]   acc_s;
  logic [NUM_CH-1:0]   gnt_s;
  logic [CH_W-1:0]     gnt_idx_s;
  logic                push_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic [EW-1:0]       ev_s;

  assign acc_s       = trace_valid & ch_enable & {NUM_CH{~stall}};
  assign fifo_full_s = (count_r == (AW+1)'(FIFO_DEPTH));
  assign out_valid   = (count_r != '0);
  assign out_data    = mem_r[rd_ptr_r];
  assign pop_s       = out_valid & out_ready;

  // Full FIFO blocks grants even when a pop is happening this cycle.
  osd_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (slot_full_r),
    .en        (~fifo_full_s),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (push_s)
  );

  // Assemble the event word from the granted slot.
  always_comb begin
    ev_s                           = '0;
    ev_s[TS_WIDTH-1:0]             = slot_ts_r[gnt_idx_s];
    ev_s[ID_LSB +: ID_W]           = slot_id_r[gnt_idx_s];
    ev_s[VALUE_LSB +: XLEN]        = slot_val_r[gnt_idx_s];
    ev_s[DROPS_LSB +: DROP_W]      = drop_r[gnt_idx_s];
    ev_s[CH_LSB +: CH_W]           = gnt_idx_s;
  end

  // Free-running timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_r <= '0;
    else      ts_r <= ts_r + TS_WIDTH'(1);
  end

  // Capture slots: a grant frees the slot, so a same-cycle sample refills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        slot_full_r[i] <= 1'b0;
        slot_id_r[i]   <= '0;
        slot_val_r[i]  <= '0;
        slot_ts_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc_s[i] && (!slot_full_r[i] || gnt_s[i])) begin
          slot_full_r[i] <= 1'b1;
          slot_id_r[i]   <= trace_id[16*i +: 16];
          slot_val_r[i]  <= trace_value[XLEN*i +: XLEN];
          slot_ts_r[i]   <= ts_r;
        end else if (gnt_s[i]) begin
          slot_full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Drop counters: count only accepted samples that found the slot occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) drop_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt_s[i])                           drop_r[i] <= '0;
        else if (acc_s[i] && slot_full_r[i])    drop_r[i] <= drop_inc(drop_r[i]);
      end
    end
  end

  // Show-ahead event FIFO; storage is cleared so out_data reads zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= ev_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
